surf5_flash_read_seq: RTL
=========================

Name: surf5_flash_read_seq

Overview:
- WISHBONE master that sequences the simple SPI core and slave-select register inside the SURF5 ID/control block to perform SPI flash READ (0x03) transactions.
- Performs the one-time dummy CCLK handover transaction after reset, then streams flash bytes out through a valid/ready byte port.
- Sits beside the PCI WISHBONE master. Bus arbitration is external; this block only issues single classic cycles.

Parameters:
- POLL_LIMIT, 1023: maximum status-register polls per SPI byte before the error abort.
- ACK_LIMIT, 255: maximum cycles waiting for wbm_ack_i per bus cycle before the error abort.
- SPCR_VAL, 8'h50: value written to SPCR (SPE=1, MSTR=1, CPOL=CPHA=0, SPR=0).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  begin transaction. Sampled only in IDLE.
- addr_i  in  24  flash byte address. Captured on accepted start.
- len_i  in  16  byte count. Captured on accepted start. 0 means no SPI access.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky error. Cleared by the next accepted start.
- dat_o  out  8  read byte.
- dat_valid_o  out  1  dat_o valid.
- dat_ready_i  in  1  consumer ready.
- wbm_cyc_o  out  1  WISHBONE cycle.
- wbm_stb_o  out  1  WISHBONE strobe.
- wbm_we_o  out  1  WISHBONE write enable.
- wbm_adr_o  out  16  byte address into the control block.
- wbm_dat_o  out  32  write data. Bits [31:8] always 0 except where stated.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  WISHBONE acknowledge.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - All outputs 0; FSM to IDLE; init_done flag cleared.
  - Any bus cycle in flight is abandoned immediately (cyc/stb low next cycle).
- Bus cycles:
  - cyc, stb, we, adr and dat are asserted together and held until the first cycle with wbm_ack_i=1.
  - All deassert the cycle after ack, giving at least one idle cycle between bus cycles.
  - Read data is captured on the ack cycle.
  - If ack is not seen within ACK_LIMIT cycles: drop cyc/stb, go to ABORT.
- Start handling:
  - start_i in IDLE is accepted, captures addr/len and clears err_o. It is ignored elsewhere.
  - len=0: IDLE -> DONE; done_o one cycle later, no bus cycles.
- Sequence:
  1. If init_done=0:
     - INIT_SPCR: write 0x30 <- SPCR_VAL.
     - SS_LOW: write 0x24 <- 0.
     - DUMMY: write 0x38 <- 0x00.
     - POLL: read 0x34 until bit0 (RFEMPTY)=0.
     - DRAIN: read 0x38, data discarded.
     - Set init_done.
  2. SS_ON: write 0x24 <- 1.
  3. TX phase, four bytes in order 0x03, addr[23:16], addr[15:8], addr[7:0]. Per byte: write 0x38, poll 0x34, read 0x38 and discard.
  4. RX phase, len bytes. Per byte: write 0x38 <- 0x00, poll, read 0x38.
     - Load dat_o with the read byte and raise dat_valid_o.
     - Stay in RX_OUT until dat_valid_o && dat_ready_i, then drop dat_valid_o the next cycle.
     - The next byte is not started until handoff.
     - dat_o is stable while valid.
  5. SS_OFF: write 0x24 <- 0.
  6. DONE: done_o=1 for one cycle, then IDLE.
- Polling:
  - Consecutive poll reads, each a full bus cycle.
  - Poll counter resets per byte.
  - POLL_LIMIT polls without RFEMPTY=0: go to ABORT.
- ABORT:
  - Attempts the SS_OFF write with its own ACK_LIMIT.
  - Sets err_o and pulses done_o whether or not that write is acked.
  - init_done stays as set. A failed initialisation leaves it 0, so init retries next start.
- RX byte counter: 16 bits, counts down, 0xFFFF maximum.
- FSM states: IDLE, INIT_SPCR, SS_LOW, DUMMY_WR, DUMMY_POLL, DUMMY_RD, SS_ON, TX_WR, TX_POLL, TX_RD, RX_WR, RX_POLL, RX_RD, RX_OUT, SS_OFF, ABORT, DONE.

Decomposition:
- Shared package surf5_ctrl_pkg holds:
  - Register offsets: SPISS 16'h0024, SPCR 16'h0030, SPSR 16'h0034, SPDR 16'h0038, SPER 16'h003C.
  - FLASH_CMD_READ 8'h03 and SPSR_RFEMPTY bit index 0.
  - FSM state enumeration.
- Sub-module surf5_wb_xfer: single-cycle WISHBONE master with req/we/adr/dat in, done/timeout/rdata out, and the ACK_LIMIT counter. The FSM issues one request per state.

Test Plan:
- Reset, then start addr=0x123456 len=2 with a slave model acking in 2 cycles and RFEMPTY=0 on the third poll:
  - Bus write order: 0x30=0x50, 0x24=0, 0x38=0, then 0x24=1, then 0x38 = 03/12/34/56.
  - Two RX bytes appear on dat_o; 0x24=0; one done_o pulse; err_o=0.
- Second start after the first: no 0x30/dummy cycles; the first bus access is the 0x24=1 write.
- len=3 with dat_ready_i low 20 cycles per byte:
  - dat_o held stable.
  - No 0x38 write issued while dat_valid_o=1.
  - Exactly 3 handshakes.
- SPSR always returns RFEMPTY=1:
  - Exactly 1023 polls, then 0x24=0 write.
  - err_o=1, done_o pulse.
- Slave never acks:
  - cyc dropped after 255 cycles, ABORT entered.
  - err_o=1; init_done stays 0, and the next start repeats init.
- rst_i low mid-RX: next cycle all outputs 0, busy_o=0, IDLE; the next start performs the dummy init again.

Source files
------------

// File: rtl/surf5_ctrl_pkg.sv
// SURF5 ID/control block shared definitions.
// Register map, flash opcodes and flash read sequencer states.
package surf5_ctrl_pkg;

    localparam logic [15:0] SPISS = 16'h0024;
    localparam logic [15:0] SPCR  = 16'h0030;
    localparam logic [15:0] SPSR  = 16'h0034;
    localparam logic [15:0] SPDR  = 16'h0038;
    localparam logic [15:0] SPER  = 16'h003C;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         SPSR_RFEMPTY   = 0;

    typedef enum logic [4:0] {
        IDLE,
        INIT_SPCR,
        SS_LOW,
        DUMMY_WR,
        DUMMY_POLL,
        DUMMY_RD,
        SS_ON,
        TX_WR,
        TX_POLL,
        TX_RD,
        RX_WR,
        RX_POLL,
        RX_RD,
        RX_OUT,
        SS_OFF,
        ABORT,
        DONE
    } flash_state_t;

    // Header byte sent at position idx: opcode then address MSB first.
    function automatic logic [7:0] tx_byte(
        input logic [1:0]  idx,
        input logic [23:0] addr
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = FLASH_CMD_READ;
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

    // Data-register read state that follows each status poll state.
    function automatic flash_state_t poll_next(input flash_state_t s);
        flash_state_t n;
        case (s)
            DUMMY_POLL: n = DUMMY_RD;
            TX_POLL:    n = TX_RD;
            default:    n = RX_RD;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/surf5_wb_xfer.sv
// Single classic-cycle WISHBONE master for the flash sequencer.
// Holds the cycle until ack or until the ack wait budget runs out.
module surf5_wb_xfer #(
    parameter int ACK_LIMIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] adr,
    input  logic [31:0] wdat,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int AW = $clog2(ACK_LIMIT + 1);

    logic [AW-1:0] ack_cnt;

    // Launch on request, end on ack or timeout; done/timeout block a relaunch.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            ack_cnt   <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            rdata     <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (wbm_cyc_o) begin
                if (wbm_ack_i || ack_cnt == AW'(ACK_LIMIT - 1)) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    wbm_adr_o <= '0;
                    wbm_dat_o <= '0;
                    done      <= wbm_ack_i;
                    timeout   <= !wbm_ack_i;
                    if (wbm_ack_i) begin
                        rdata <= wbm_dat_i;
                    end
                end else begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
            end else if (req && !done && !timeout) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= we;
                wbm_adr_o <= adr;
                wbm_dat_o <= wdat;
                ack_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/surf5_flash_read_seq.sv
// SPI flash READ sequencer driving the SURF5 simple SPI core over WISHBONE.
// Does the CCLK handover dummy once, then streams bytes on a valid/ready port.
module surf5_flash_read_seq
    import surf5_ctrl_pkg::*;
#(
    parameter int         POLL_LIMIT = 1023,
    parameter int         ACK_LIMIT  = 255,
    parameter logic [7:0] SPCR_VAL   = 8'h50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  dat_o,
    output logic        dat_valid_o,
    input  logic        dat_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    flash_state_t  state;
    logic          init_done;
    logic [23:0]   addr_q;
    logic [15:0]   len_q;
    logic [1:0]    tx_idx;
    logic [PW-1:0] poll_cnt;

    logic          req;
    logic          req_we;
    logic [15:0]   req_adr;
    logic [31:0]   req_dat;
    logic          xfer_done;
    logic          xfer_to;
    logic [31:0]   xfer_rdata;
    logic          unused_rdata;

    assign unused_rdata = ^xfer_rdata[31:8];

    surf5_wb_xfer #(
        .ACK_LIMIT(ACK_LIMIT)
    ) u_xfer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (req),
        .we       (req_we),
        .adr      (req_adr),
        .wdat     (req_dat),
        .done     (xfer_done),
        .timeout  (xfer_to),
        .rdata    (xfer_rdata),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    // One bus request per state: the register access that state performs.
    always_comb begin
        req     = 1'b0;
        req_we  = 1'b0;
        req_adr = '0;
        req_dat = '0;
        unique case (state)
            INIT_SPCR: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_adr = SPCR;
                req_dat = {24'h0, SPCR_VAL};
            end
            SS_LOW, SS_OFF, ABORT: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_adr = SPISS;
            end
            SS_ON: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_adr = SPISS;
                req_dat = 32'h1;
            end
            DUMMY_WR, RX_WR: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_adr = SPDR;
            end
            TX_WR: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_adr = SPDR;
                req_dat = {24'h0, tx_byte(tx_idx, addr_q)};
            end
            DUMMY_POLL, TX_POLL, RX_POLL: begin
                req     = 1'b1;
                req_adr = SPSR;
            end
            DUMMY_RD, TX_RD, RX_RD: begin
                req     = 1'b1;
                req_adr = SPDR;
            end
            default: ;
        endcase
    end

    // Sequencer: advances on each completed access, aborts on timeouts.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            init_done   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            tx_idx      <= '0;
            poll_cnt    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (xfer_to && state != ABORT) begin
                state <= ABORT;
                err_o <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: if (start_i) begin
                        addr_q <= addr_i;
                        len_q  <= len_i;
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (init_done) begin
                            state <= SS_ON;
                        end else begin
                            state <= INIT_SPCR;
                        end
                    end
                    INIT_SPCR: if (xfer_done) state <= SS_LOW;
                    SS_LOW:    if (xfer_done) state <= DUMMY_WR;
                    DUMMY_WR: if (xfer_done) begin
                        state    <= DUMMY_POLL;
                        poll_cnt <= '0;
                    end
                    DUMMY_POLL, TX_POLL, RX_POLL: if (xfer_done) begin
                        if (!xfer_rdata[SPSR_RFEMPTY]) begin
                            state <= poll_next(state);
                        end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                            state <= ABORT;
                            err_o <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                    DUMMY_RD: if (xfer_done) begin
                        init_done <= 1'b1;
                        state     <= SS_ON;
                    end
                    SS_ON: if (xfer_done) begin
                        state  <= TX_WR;
                        tx_idx <= '0;
                    end
                    TX_WR: if (xfer_done) begin
                        state    <= TX_POLL;
                        poll_cnt <= '0;
                    end
                    TX_RD: if (xfer_done) begin
                        if (tx_idx == 2'd3) begin
                            state <= RX_WR;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                            state  <= TX_WR;
                        end
                    end
                    RX_WR: if (xfer_done) begin
                        state    <= RX_POLL;
                        poll_cnt <= '0;
                    end
                    RX_RD: if (xfer_done) begin
                        dat_o       <= xfer_rdata[7:0];
                        dat_valid_o <= 1'b1;
                        state       <= RX_OUT;
                    end
                    RX_OUT: if (dat_ready_i) begin
                        dat_valid_o <= 1'b0;
                        len_q       <= len_q - 1'b1;
                        state       <= (len_q == 16'd1) ? SS_OFF : RX_WR;
                    end
                    SS_OFF: if (xfer_done) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                    ABORT: if (xfer_done || xfer_to) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                    DONE: begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
